debounce_fsm: RTL

- Cleans a raw mechanical switch or pushbutton signal and produces a stable level, plus a one-cycle tick on each debounced rising edge.
- Sits directly upstream of the edge-detector stage. Its db_level output feeds that stage's level input.
- Internals: a 2-flop synchronizer, then a 4-state FSM with a down-counter that requires the input to hold stable for 2^N clocks before the output changes.

---
 rtl/debounce_fsm_pkg.sv | 17 +
 rtl/debounce_fsm_sync_2ff.sv | 27 ++
 rtl/debounce_fsm.sv | 93 +++++++++
 3 files changed

// File: rtl/debounce_fsm_pkg.sv
// Shared definitions for the switch debouncer: state encoding and default stability width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package debounce_fsm_pkg;

  // Default stability counter width: 2^19 clocks is about 10.5 ms at 50 MHz.
  localparam int DB_N_DEFAULT = 19;

  // db_level is 1 exactly in ONE and WAIT0.
  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } db_state_e;

endpackage

// File: rtl/debounce_fsm_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Latency: q follows d two rising edges of clk later.
// Backpressure: none; samples every cycle.
// Ports: clk, reset (sync active-high, clears both flops), d (async in), q (synchronized out).
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/debounce_fsm.sv
// Switch debouncer: stable level plus a one-cycle tick on each accepted rising edge.
// Latency: 2^N + 2 edges from the first edge that samples a new sw level.
// Backpressure: none; the output level and tick are free-running.
// Ports: clk, reset (sync active-high), sw (raw async switch), db_level (debounced level),
//        db_tick (Mealy pulse, one cycle, on a debounced 0->1 transition).
module debounce_fsm
  import debounce_fsm_pkg::*;
#(
  parameter int N = DB_N_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db_level,
  output logic db_tick
);

  localparam logic [N-1:0] CNT_MAX = '1;
  localparam logic [N-1:0] CNT_ONE = N'(1);

  logic          sw_s;
  db_state_e     state_q, state_d;
  logic [N-1:0]  cnt_q, cnt_d;
  logic          tick_c;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sw),
    .q     (sw_s)
  );

  // The counter reloads on entry to a WAIT state and counts down to zero;
  // the WAIT state is left on the cycle it is seen at zero, so each WAIT
  // lasts exactly 2^N cycles when the input holds steady.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_c  = 1'b0;
    case (state_q)
      ZERO: begin
        if (sw_s) begin
          state_d = WAIT1;
          cnt_d   = CNT_MAX;
        end
      end
      WAIT1: begin
        if (!sw_s) begin
          state_d = ZERO;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          tick_c  = 1'b1;
          state_d = ONE;
        end
      end
      ONE: begin
        if (!sw_s) begin
          state_d = WAIT0;
          cnt_d   = CNT_MAX;
        end
      end
      WAIT0: begin
        // Returning to ONE emits no tick: the level never dropped.
        if (sw_s) begin
          state_d = ONE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = ZERO;
        end
      end
      default: begin
        state_d = ZERO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ZERO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db_level = (state_q == ONE) || (state_q == WAIT0);
  // Masked during reset so a pending WAIT1 expiry cannot leak a tick.
  assign db_tick  = tick_c & ~reset;

endmodule
